// File: rtl/quad_step_decoder_pkg.sv
// Shared constants and decode helper for the quadrature step decoder.
package quad_step_decoder_pkg;

  // A/B pair values in forward Gray order: 00 -> 01 -> 11 -> 10 -> 00.
  typedef enum logic [1:0] {
    AB_00 = 2'b00,
    AB_01 = 2'b01,
    AB_11 = 2'b11,
    AB_10 = 2'b10
  } ab_e;

  // Result of comparing the previous and newly accepted A/B pair.
  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DN   = 2'd2,
    STEP_ERR  = 2'd3
  } step_e;

  localparam int unsigned DEFAULT_WIDTH       = 8;
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;
  localparam int unsigned DEFAULT_FILTER      = 3;

  // Classify a prev -> next transition; a two-bit change is illegal.
  function automatic step_e decode_step(input logic [1:0] prev, input logic [1:0] nxt);
    step_e res;
    res = STEP_NONE;
    case ({prev, nxt})
      {AB_00, AB_01}, {AB_01, AB_11}, {AB_11, AB_10}, {AB_10, AB_00}: res = STEP_UP;
      {AB_00, AB_10}, {AB_10, AB_11}, {AB_11, AB_01}, {AB_01, AB_00}: res = STEP_DN;
      default: res = (prev == nxt) ? STEP_NONE : STEP_ERR;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/quad_step_decoder_sync_filter.sv
// Synchroniser plus stability filter for the A/B pair. Emits the currently
// filtered pair, the candidate about to replace it, and an accept strobe.
module quad_sync_filter
  import quad_step_decoder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int unsigned FILTER      = DEFAULT_FILTER
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_in,
  input  logic       b_in,
  output logic [1:0] ab_filt,
  output logic [1:0] ab_new,
  output logic       accept
);

  localparam int unsigned STAB_W = $clog2(FILTER + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(FILTER);

  logic [SYNC_STAGES-1:0] a_sync_q, a_sync_d;
  logic [SYNC_STAGES-1:0] b_sync_q, b_sync_d;
  logic [1:0]             s_ab;
  logic [1:0]             cand_q, cand_d;
  logic [1:0]             filt_q, filt_d;
  logic [STAB_W-1:0]      stab_q, stab_d;
  logic                   init_q, init_d;
  logic                   stable;

  assign s_ab    = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
  assign ab_filt = filt_q;
  assign ab_new  = cand_q;

  // Shift both channels through the synchroniser chain.
  always_comb begin
    a_sync_d = {a_sync_q[SYNC_STAGES-2:0], a_in};
    b_sync_d = {b_sync_q[SYNC_STAGES-2:0], b_in};
  end

  // Stability count, acceptance and first-value initialisation.
  // Acceptance uses the next stab value so the accept lands on the same edge
  // the count reaches FILTER, giving SYNC_STAGES + FILTER + 1 edge-to-pulse.
  always_comb begin
    cand_d = s_ab;
    stab_d = '0;
    filt_d = filt_q;
    init_d = init_q;
    accept = 1'b0;
    if (s_ab == cand_q) begin
      stab_d = (stab_q == STAB_MAX) ? STAB_MAX : stab_q + 1'b1;
    end
    stable = (s_ab == cand_q) && (stab_d == STAB_MAX);
    if (stable) begin
      if (!init_q) begin
        filt_d = cand_q;
        init_d = 1'b1;
      end else if (cand_q != filt_q) begin
        filt_d = cand_q;
        accept = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
      cand_q   <= '0;
      stab_q   <= '0;
      filt_q   <= '0;
      init_q   <= 1'b0;
    end else begin
      a_sync_q <= a_sync_d;
      b_sync_q <= b_sync_d;
      cand_q   <= cand_d;
      stab_q   <= stab_d;
      filt_q   <= filt_d;
      init_q   <= init_d;
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature decoder top: step pulses, direction, wrapping position count
// and sticky illegal-transition flag.
module quad_step_decoder
  import quad_step_decoder_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int unsigned FILTER      = DEFAULT_FILTER
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             err_clr,
  output logic             step_up,
  output logic             step_dn,
  output logic             dir,
  output logic [WIDTH-1:0] count,
  output logic             err
);

  logic [1:0]       ab_filt, ab_new;
  logic             accept;
  step_e            step;
  logic             step_up_q, step_up_d;
  logic             step_dn_q, step_dn_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             err_q, err_d;

  quad_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER      (FILTER)
  ) u_sync_filter (
    .clk     (clk),
    .rst     (rst),
    .a_in    (a_in),
    .b_in    (b_in),
    .ab_filt (ab_filt),
    .ab_new  (ab_new),
    .accept  (accept)
  );

  assign step_up = step_up_q;
  assign step_dn = step_dn_q;
  assign dir     = dir_q;
  assign count   = count_q;
  assign err     = err_q;

  // Decode accepted transitions into pulses, count and error updates.
  always_comb begin
    step      = accept ? decode_step(ab_filt, ab_new) : STEP_NONE;
    step_up_d = 1'b0;
    step_dn_d = 1'b0;
    dir_d     = dir_q;
    count_d   = count_q;
    err_d     = err_clr ? 1'b0 : err_q;
    case (step)
      STEP_UP: begin
        step_up_d = 1'b1;
        dir_d     = 1'b1;
        count_d   = count_q + 1'b1;
      end
      STEP_DN: begin
        step_dn_d = 1'b1;
        dir_d     = 1'b0;
        count_d   = count_q - 1'b1;
      end
      STEP_ERR: err_d = 1'b1;
      default: ;
    endcase
    if (load) begin
      count_d = data;
    end
  end

  // Output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
      dir_q     <= 1'b0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      step_up_q <= step_up_d;
      step_dn_q <= step_dn_d;
      dir_q     <= dir_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

endmodule
